operand_loader: RTL and testbench

// - Upstream feeder for the generic1 operand consumer.
// - Collects a little-endian byte stream into six operand fields: a, b, enf, load, qtd, base.
// - Presents a complete, stable operand set with a valid/ack handshake.
// - Shadow-buffers the frame being filled, so outputs change only on successful frame completion.

---
 rtl/operand_loader.sv | 167 ++++++++++++++++
 tb/tb_operand_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
`default_nettype none
//==============================================================================
// Module : operand_loader
// Collects a little-endian byte stream into six shadow-buffered operands
// (a, b, enf, load, qtd, base) and hands them off with a valid/ack pair.
// Optional trailing XOR checksum byte: define OPLOAD_CHECKSUM_EN.
// Rev    : 1.0
//==============================================================================
module operand_loader #(
   parameter int bus_width = 32
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   input  logic                 in_first,
   output logic                 in_ready,
   output logic [bus_width:0]   a,
   output logic [bus_width:0]   b,
   output logic [bus_width:0]   enf,
   output logic [bus_width:0]   load,
   output logic [bus_width:0]   qtd,
   output logic [bus_width:0]   base,
   output logic                 ops_valid,
   input  logic                 ops_ack,
   output logic                 frame_err
);
   localparam int c_NB     = (bus_width + 8) / 8;
   localparam int c_OW     = bus_width + 1;
   localparam int c_NBYTES = 6 * c_NB;
   localparam int c_CNT_W  = $clog2(c_NBYTES + 1);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NBYTES - 1);
   localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
`ifdef OPLOAD_CHECKSUM_EN
      S_CHECK = 2'd3,
`endif
      S_HOLD  = 2'd2
   } state_t;

   state_t                      r_state, w_next_state;
   logic [c_CNT_W-1:0]          r_cnt, w_ncnt, w_widx;
   logic [6*c_OW-1:0]           r_shadow, w_shadow_next;
   logic [5:0][c_OW-1:0]        r_ops;
   logic                        r_frame_err;
   logic                        w_we, w_err, w_load, w_accept;
`ifdef OPLOAD_CHECKSUM_EN
   logic [7:0]                  r_xor;
`endif

   assign in_ready  = (r_state != S_HOLD);
   assign ops_valid = (r_state == S_HOLD);
   assign frame_err = r_frame_err;
   assign w_accept  = in_valid && in_ready;

   assign a    = r_ops[0];
   assign b    = r_ops[1];
   assign enf  = r_ops[2];
   assign load = r_ops[3];
   assign qtd  = r_ops[4];
   assign base = r_ops[5];

   // Shadow holds only the meaningful bits of each field; the top byte lane
   // of a field keeps just the bits up to bus_width.
   for (genvar gi = 0; gi < c_NBYTES; gi++) begin : g_byte
      localparam int c_J   = gi % c_NB;
      localparam int c_LO  = (gi / c_NB) * c_OW + c_J * 8;
      localparam int c_W   = ((c_OW - c_J * 8) >= 8) ? 8 : (c_OW - c_J * 8);
      localparam logic [c_CNT_W-1:0] c_IDX = c_CNT_W'(gi);
      assign w_shadow_next[c_LO +: c_W] = (w_we && (w_widx == c_IDX)) ?
                                          in_data[c_W-1:0] : r_shadow[c_LO +: c_W];
   end

   always_comb begin
      w_next_state = r_state;
      w_ncnt       = r_cnt;
      w_widx       = r_cnt;
      w_we         = 1'b0;
      w_err        = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && in_first) begin
               w_we         = 1'b1;
               w_widx       = '0;
               w_ncnt       = c_ONE;
               w_next_state = S_FILL;
            end
         end
         S_FILL: begin
            if (w_accept) begin
               w_we = 1'b1;
               if (in_first) begin
                  w_err  = 1'b1;
                  w_widx = '0;
                  w_ncnt = c_ONE;
               end else if (r_cnt == c_LAST) begin
                  w_ncnt = '0;
`ifdef OPLOAD_CHECKSUM_EN
                  w_next_state = S_CHECK;
`else
                  w_next_state = S_HOLD;
                  w_load       = 1'b1;
`endif
               end else begin
                  w_ncnt = r_cnt + c_ONE;
               end
            end
         end
`ifdef OPLOAD_CHECKSUM_EN
         S_CHECK: begin
            if (w_accept) begin
               if (in_first) begin
                  w_we         = 1'b1;
                  w_err        = 1'b1;
                  w_widx       = '0;
                  w_ncnt       = c_ONE;
                  w_next_state = S_FILL;
               end else if (in_data == r_xor) begin
                  w_load       = 1'b1;
                  w_next_state = S_HOLD;
               end else begin
                  w_err        = 1'b1;
                  w_next_state = S_IDLE;
               end
            end
         end
`endif
         S_HOLD: begin
            if (ops_ack) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_shadow    <= '0;
         r_ops       <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_cnt       <= w_ncnt;
         r_shadow    <= w_shadow_next;
         r_frame_err <= w_err;
         if (w_load) r_ops <= w_shadow_next;
      end
   end

`ifdef OPLOAD_CHECKSUM_EN
   // Running XOR over all full field bytes, restarted by byte 0.
   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         r_xor <= '0;
      end else if (w_we) begin
         r_xor <= (w_widx == '0) ? in_data : (r_xor ^ in_data);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
//==============================================================================
// Module : tb_operand_loader
// Directed self-checking bench for operand_loader with a scoreboard of
// expected operand sets.
// Rev    : 1.0
//==============================================================================
module tb_operand_loader;
   localparam int c_BW     = 32;
   localparam int c_NB     = 5;
   localparam int c_OW     = c_BW + 1;
   localparam int c_NBYTES = 6 * c_NB;

   typedef logic [5:0][c_OW-1:0] opset_t;

   logic              sysclk = 1'b0;
   logic              reset;
   logic [7:0]        in_data;
   logic              in_valid, in_first, in_ready;
   logic [c_OW-1:0]   a, b, enf, load, qtd, base;
   logic              ops_valid, ops_ack, frame_err;

   int                n_assert  = 0;
   int                n_fail    = 0;
   int                err_cnt   = 0;
   int                vld_rises = 0;
   int                hold_acc  = 0;
   logic              vld_d     = 1'b0;
   opset_t            sb_q[$];
   logic [7:0]        fr [c_NBYTES];

   always #5 sysclk = ~sysclk;

   operand_loader #(.bus_width(c_BW)) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .enf       (enf),
      .load      (load),
      .qtd       (qtd),
      .base      (base),
      .ops_valid (ops_valid),
      .ops_ack   (ops_ack),
      .frame_err (frame_err)
   );

   always @(negedge sysclk) begin
      vld_d <= ops_valid;
      if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
      if (ops_valid === 1'b1 && vld_d !== 1'b1) vld_rises <= vld_rises + 1;
   end

   always @(posedge sysclk) begin
      if (in_valid && in_ready && ops_valid) hold_acc <= hold_acc + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic first);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_first = first;
      for (int k = 0; k < 20 && !done; k++) begin
         done = (in_ready === 1'b1);
         tick();
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      if (!done) chk("send_timeout", 64'd0, 64'd1);
   endtask

   // Reference packing: little-endian bytes per field, truncated to c_OW bits.
   function automatic opset_t model();
      opset_t               r;
      logic [8*c_NB-1:0]    v;
      for (int f = 0; f < 6; f++) begin
         for (int j = 0; j < c_NB; j++) v[8*j +: 8] = fr[c_NB*f + j];
         r[f] = v[c_OW-1:0];
      end
      return r;
   endfunction

   task automatic send_frame(input int n, input bit bad_ck);
      logic [7:0] x;
      x = 8'h00;
      if (n == c_NBYTES && !bad_ck) sb_q.push_back(model());
      for (int i = 0; i < n; i++) begin
         send_byte(fr[i], i == 0);
         x ^= fr[i];
      end
`ifdef OPLOAD_CHECKSUM_EN
      if (n == c_NBYTES) send_byte(bad_ck ? ~x : x, 1'b0);
`endif
   endtask

   task automatic check_ops(input string tag);
      opset_t e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_a"},    a,    e[0]);
         chk({tag, "_b"},    b,    e[1]);
         chk({tag, "_enf"},  enf,  e[2]);
         chk({tag, "_load"}, load, e[3]);
         chk({tag, "_qtd"},  qtd,  e[4]);
         chk({tag, "_base"}, base, e[5]);
      end
   endtask

   task automatic ack_once();
      ops_ack = 1'b1;
      tick();
      ops_ack = 1'b0;
   endtask

   initial begin
      opset_t   got;
      opset_t   last_exp;
      bit       stable;
      int       e0, v0;

      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_first = 1'b0; ops_ack = 1'b0;
      repeat (3) tick();
      chk("rst_a", a, 0);
      chk("rst_base", base, 0);
      chk("rst_valid", ops_valid, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_ready", in_ready, 1);
      reset = 1'b0;
      tick();

      // Frame of 0x01..0x1E, ack in the third valid cycle
      for (int i = 0; i < c_NBYTES; i++) fr[i] = 8'(i + 1);
      send_frame(c_NBYTES, 1'b0);
      chk("t1_valid_c1", ops_valid, 1);
      chk("t1_ready_hold", in_ready, 0);
      check_ops("t1");
      chk("t1_a_const", a, 33'h1_04030201);
      chk("t1_b_const", b, 33'h0_09080706);
      chk("t1_base_const", base, 33'h0_1D1C1B1A);
      tick();
      chk("t1_valid_c2", ops_valid, 1);
      tick();
      chk("t1_valid_c3", ops_valid, 1);
      ack_once();
      chk("t1_valid_drop", ops_valid, 0);
      chk("t1_ready_back", in_ready, 1);
      chk("t1_rises", vld_rises, 1);
      chk("t1_no_err", err_cnt, 0);

      // Stray bytes in IDLE (with a spurious ack) then the same frame
      ops_ack = 1'b1;
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
      ops_ack = 1'b0;
      tick();
      chk("t2_no_err", err_cnt, 0);
      chk("t2_no_valid", ops_valid, 0);
      chk("t2_a_kept", a, 33'h1_04030201);
      send_frame(c_NBYTES, 1'b0);
      chk("t2_valid", ops_valid, 1);
      check_ops("t2");
      chk("t2_err", err_cnt, 0);
      ack_once();

      // Restart at byte 12, then a full frame of 0xFF
      send_frame(12, 1'b0);
      chk("t3_a_kept", a, 33'h1_04030201);
      chk("t3_no_valid", ops_valid, 0);
      for (int i = 0; i < c_NBYTES; i++) fr[i] = 8'hFF;
      send_frame(c_NBYTES, 1'b0);
      tick();
      chk("t3_err_once", err_cnt, 1);
      chk("t3_valid", ops_valid, 1);
      check_ops("t3");
      chk("t3_qtd_const", qtd, 33'h1_FFFFFFFF);
      chk("t3_rises", vld_rises, 3);

      // Random input activity during HOLD with no ack
      stable = 1'b1;
      for (int k = 0; k < 50; k++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_first = 1'($urandom_range(0, 1));
         in_data  = 8'($urandom);
         tick();
         got = {base, qtd, load, enf, b, a};
         if (got !== {6{33'h1_FFFFFFFF}} || ops_valid !== 1'b1) stable = 1'b0;
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      chk("t4_stable", stable, 1);
      chk("t4_hold_acc", hold_acc, 0);
      chk("t4_err", err_cnt, 1);
      ack_once();

      // Reset at byte 20, then a fresh random frame
      for (int i = 0; i < c_NBYTES; i++) fr[i] = 8'($urandom);
      send_frame(20, 1'b0);
      #1;
      reset = 1'b1;
      #1;
      chk("t5_rst_a", a, 0);
      chk("t5_rst_enf", enf, 0);
      chk("t5_rst_valid", ops_valid, 0);
      tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < c_NBYTES; i++) fr[i] = 8'($urandom);
      last_exp = model();
      send_frame(c_NBYTES, 1'b0);
      chk("t5_valid", ops_valid, 1);
      check_ops("t5");
      ack_once();

`ifdef OPLOAD_CHECKSUM_EN
      // Bad checksum rejected, then a good frame accepted
      e0 = err_cnt;
      v0 = vld_rises;
      for (int i = 0; i < c_NBYTES; i++) fr[i] = 8'($urandom);
      send_frame(c_NBYTES, 1'b1);
      tick();
      chk("t6_err", err_cnt, e0 + 1);
      chk("t6_no_valid", ops_valid, 0);
      chk("t6_rises", vld_rises, v0);
      got = {base, qtd, load, enf, b, a};
      chk("t6_kept_lo", got[63:0], last_exp[63:0]);
      chk("t6_kept_base", base, last_exp[5]);
      send_frame(c_NBYTES, 1'b0);
      chk("t6_valid", ops_valid, 1);
      check_ops("t6");
      ack_once();
`else
      e0 = err_cnt;
      v0 = vld_rises;
      chk("t6_err_total", e0, 1);
      chk("t6_rises_total", v0, 4);
      got = {base, qtd, load, enf, b, a};
      chk("t6_kept_base", got[5], last_exp[5]);
`endif

      chk("sb_drained", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
